conv_window_5x5: RTL and testbench

- Upstream feeder for the 5x5 MAC stage. Takes a raster-order pixel stream, one pixel per accepted cycle.
- Holds 4 previous image rows in line buffers plus a 5x5 register window.
- Presents each fully-inside 5x5 window as five packed row buses, i_1..i_5, which wire straight into the MAC's i_1..i_5 inputs.
- Asserts out_valid for exactly (img_height-4)*(img_width-4) windows per frame.

---
 rtl/conv_defs_pkg.sv | 14 +
 rtl/conv_window_5x5_line_buffer.sv | 26 ++
 rtl/conv_window_5x5.sv | 127 ++++++++++++
 tb/tb_conv_window_5x5.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_defs_pkg.sv
// Shared constants for the 5x5 convolution datapath (window feeder and MAC).
// Row-bus packing: slice [pix_w*j +: pix_w] holds window column j. Column 0 is
// the leftmost, oldest pixel and column KERNEL_SIZE-1 is the newest. This is the
// same order as the kernel weights w_k in the MAC.
package conv_defs;
    localparam int KERNEL_SIZE     = 5;
    localparam int LB_COUNT        = KERNEL_SIZE - 1;
    localparam int PIXEL_W_DEFAULT = 8;

    // LSB position of window column `col` inside a packed row bus.
    function automatic int col_lsb(input int col, input int pix_w);
        return col * pix_w;
    endfunction
endpackage

// File: rtl/conv_window_5x5_line_buffer.sv
// line_buffer: single-port memory that holds one image row.
// Ports: clk (clock), we (write enable), addr (column address),
//        wdata (write data), rdata (combinational read data; a write in this
//        cycle only shows up on the next cycle, so reads see the old value).
// The memory is not reset. Until a location has been written its contents are
// undefined, and valid masking downstream hides any such values.
module line_buffer #(
    parameter int data_size = 8,
    parameter int depth     = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(depth)-1:0] addr,
    input  logic [data_size-1:0]     wdata,
    output logic [data_size-1:0]     rdata
);
    logic [data_size-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/conv_window_5x5.sv
// conv_window_5x5: builds 5x5 windows from a raster-order pixel stream.
// Ports: clk, rst_n (async active-low), frame_start (sync frame restart),
//        in_valid/in_data (pixel stream), i_1..i_5 (window rows, oldest first,
//        column 0 in the low slice), out_valid (window fully inside image),
//        out_row/out_col (bottom-right pixel position), frame_done (pulses once
//        after the last pixel of a frame is accepted).
module conv_window_5x5
    import conv_defs::*;
#(
    parameter int data_size  = PIXEL_W_DEFAULT,
    parameter int img_width  = 32,
    parameter int img_height = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          in_valid,
    input  logic [data_size-1:0]          in_data,
    output logic [data_size*5-1:0]        i_1,
    output logic [data_size*5-1:0]        i_2,
    output logic [data_size*5-1:0]        i_3,
    output logic [data_size*5-1:0]        i_4,
    output logic [data_size*5-1:0]        i_5,
    output logic                          out_valid,
    output logic [$clog2(img_height)-1:0] out_row,
    output logic [$clog2(img_width)-1:0]  out_col,
    output logic                          frame_done
);
    localparam int CW = $clog2(img_width);
    localparam int RW = $clog2(img_height);
    localparam int RB = data_size * KERNEL_SIZE;

    localparam logic [CW-1:0] COL_LAST = CW'(img_width - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(img_height - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(KERNEL_SIZE - 1);

    logic [CW-1:0]        col_q, col_d, col_cur;
    logic [RW-1:0]        row_q, row_d, row_cur;
    logic [data_size-1:0] lb_rd   [LB_COUNT];
    logic [data_size-1:0] lb_wd   [LB_COUNT];
    logic [data_size-1:0] new_col [KERNEL_SIZE];
    logic [RB-1:0]        win_q   [KERNEL_SIZE];
    logic                 out_valid_q, frame_done_q;
    logic [RW-1:0]        out_row_q;
    logic [CW-1:0]        out_col_q;

    // frame_start makes the pixel in the same cycle (0,0), so the position
    // used for this cycle's addressing and flags is overridden, not just the
    // next-state value.
    assign col_cur = frame_start ? '0 : col_q;
    assign row_cur = frame_start ? '0 : row_q;

    always_comb begin
        col_d = col_cur;
        row_d = row_cur;
        if (in_valid) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
            end
        end
    end

    // lb0 holds row r-1 and lb3 holds row r-4. Each buffer takes the old
    // contents of the buffer one row newer at the same column.
    for (genvar g = 0; g < LB_COUNT; g++) begin : g_lb
        if (g == 0) begin : g_first
            assign lb_wd[g] = in_data;
        end else begin : g_chain
            assign lb_wd[g] = lb_rd[g-1];
        end

        line_buffer #(
            .data_size(data_size),
            .depth    (img_width)
        ) u_lb (
            .clk  (clk),
            .we   (in_valid),
            .addr (col_cur),
            .wdata(lb_wd[g]),
            .rdata(lb_rd[g])
        );

        assign new_col[g] = lb_rd[LB_COUNT-1-g];
    end
    assign new_col[KERNEL_SIZE-1] = in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= in_valid && (row_cur >= ROW_WIN) && (col_cur >= COL_WIN);
            frame_done_q <= in_valid && (row_cur == ROW_LAST) && (col_cur == COL_LAST);
            if (in_valid) begin
                out_row_q <= row_cur;
                out_col_q <= col_cur;
                // Newest column enters the high slice and the oldest drops out the bottom.
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    win_q[k] <= {new_col[k], win_q[k][RB-1:data_size]};
                end
            end
        end
    end

    assign i_1        = win_q[0];
    assign i_2        = win_q[1];
    assign i_3        = win_q[2];
    assign i_4        = win_q[3];
    assign i_5        = win_q[4];
    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_5x5.sv
module tb_conv_window_5x5;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic [39:0] i_1, i_2, i_3, i_4, i_5;
    logic        out_valid, frame_done;
    logic [2:0]  out_row, out_col;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the frame as an image indexed by position, plus the
    // model's own raster position.
    logic [7:0]  img [H][W];
    int          mr = 0, mc = 0;
    logic        exp_valid, exp_done;
    logic [2:0]  exp_r, exp_c;
    logic [39:0] exp_win [5];

    conv_window_5x5 #(.data_size(8), .img_width(W), .img_height(H)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .in_valid(in_valid), .in_data(in_data),
        .i_1(i_1), .i_2(i_2), .i_3(i_3), .i_4(i_4), .i_5(i_5),
        .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] win_row(input int r, input int c);
        logic [39:0] res;
        res = '0;
        for (int j = 0; j < 5; j++) res[j*8 +: 8] = img[r][c-4+j];
        return res;
    endfunction

    // One clock of stimulus; afterwards the outputs are sampled 1 time unit
    // past the edge and exp_* hold the model's expectation for them.
    task automatic step(input logic v, input logic fs, input logic [7:0] d);
        in_valid = v; frame_start = fs; in_data = d;
        @(posedge clk); #1;
        exp_valid = 1'b0; exp_done = 1'b0;
        if (fs) begin mr = 0; mc = 0; end
        if (v) begin
            img[mr][mc] = d;
            if (mr >= 4 && mc >= 4) begin
                exp_valid = 1'b1;
                exp_r = mr[2:0]; exp_c = mc[2:0];
                for (int k = 0; k < 5; k++) exp_win[k] = win_row(mr - 4 + k, mc);
            end
            if (mr == H-1 && mc == W-1) exp_done = 1'b1;
            mc++;
            if (mc == W) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
        end
        in_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ((|{out_valid, frame_done, out_row, out_col, i_1, i_2, i_3, i_4, i_5}) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%b r=%0d c=%0d i1=%h i5=%h want all zero",
                     out_valid, frame_done, out_row, out_col, i_1, i_5);
        end
        #3 rst_n = 1'b1;
        mr = 0; mc = 0;
        step(1'b0, 1'b0, 8'h00);
        n_tests++;
        if ((|{out_valid, frame_done, out_row, out_col, i_1}) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b d=%b r=%0d c=%0d want all zero",
                     out_valid, frame_done, out_row, out_col);
        end
    endtask

    task automatic test_continuous();
        int nv = 0, nd = 0;
        for (int idx = 0; idx < W*H; idx++) begin
            step(1'b1, 1'b0, 8'(idx));
            nv += int'(out_valid); nd += int'(frame_done);
            n_tests++;
            if (out_valid !== exp_valid || frame_done !== exp_done ||
                (exp_valid && {i_1, i_2, i_3, i_4, i_5, out_row, out_col} !==
                 {exp_win[0], exp_win[1], exp_win[2], exp_win[3], exp_win[4], exp_r, exp_c})) begin
                n_fail++;
                $display("FAIL cont_px%0d: got v=%b d=%b r=%0d c=%0d i1=%h i5=%h want v=%b d=%b r=%0d c=%0d i1=%h i5=%h",
                         idx, out_valid, frame_done, out_row, out_col, i_1, i_5,
                         exp_valid, exp_done, exp_r, exp_c, exp_win[0], exp_win[4]);
            end
            if (idx == 36) begin
                n_tests++;
                if (out_valid !== 1'b1 || i_1 !== 40'h0403020100 || i_5 !== 40'h2423222120 ||
                    out_row !== 3'd4 || out_col !== 3'd4) begin
                    n_fail++;
                    $display("FAIL cont_first_window: got v=%b i1=%h i5=%h r=%0d c=%0d want v=1 i1=0403020100 i5=2423222120 r=4 c=4",
                             out_valid, i_1, i_5, out_row, out_col);
                end
            end
            if (idx == 47) begin
                n_tests++;
                if (i_1 !== 40'h0F0E0D0C0B || i_3 !== 40'h1F1E1D1C1B || i_4 !== 40'h2726252423 ||
                    frame_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cont_window_5_7: got i1=%h i3=%h i4=%h d=%b want i1=0f0e0d0c0b i3=1f1e1d1c1b i4=2726252423 d=1",
                             i_1, i_3, i_4, frame_done);
                end
            end
        end
        n_tests++;
        if (nv != 8 || nd != 1) begin
            n_fail++;
            $display("FAIL cont_counts: got valid=%0d done=%0d want valid=8 done=1", nv, nd);
        end
    endtask

    task automatic test_random_idle();
        int idx = 0, nv = 0, guard = 0;
        logic v;
        while (idx < W*H && guard < 2000) begin
            guard++;
            v = 1'($urandom_range(1));
            step(v, 1'b0, v ? 8'(idx) : 8'($urandom));
            nv += int'(out_valid);
            n_tests++;
            if (out_valid !== exp_valid || frame_done !== exp_done ||
                (exp_valid && {i_1, i_2, i_3, i_4, i_5, out_row, out_col} !==
                 {exp_win[0], exp_win[1], exp_win[2], exp_win[3], exp_win[4], exp_r, exp_c})) begin
                n_fail++;
                $display("FAIL idle_px%0d_v%b: got v=%b d=%b r=%0d c=%0d i1=%h i5=%h want v=%b d=%b r=%0d c=%0d i1=%h i5=%h",
                         idx, v, out_valid, frame_done, out_row, out_col, i_1, i_5,
                         exp_valid, exp_done, exp_r, exp_c, exp_win[0], exp_win[4]);
            end
            if (v) idx++;
        end
        n_tests++;
        if (idx != W*H || nv != 8) begin
            n_fail++;
            $display("FAIL idle_counts: got pixels=%0d valid=%0d want pixels=48 valid=8", idx, nv);
        end
    endtask

    task automatic test_frame_start();
        int nd = 0, first_v = -1;
        for (int idx = 0; idx < 26; idx++) begin
            step(1'b1, 1'b0, 8'(idx));
            nd += int'(frame_done);
            n_tests++;
            if (out_valid !== exp_valid || frame_done !== exp_done) begin
                n_fail++;
                $display("FAIL fs_old_px%0d: got v=%b d=%b want v=%b d=%b",
                         idx, out_valid, frame_done, exp_valid, exp_done);
            end
        end
        for (int idx = 0; idx < W*H; idx++) begin
            step(1'b1, idx == 0, (idx == 0) ? 8'h55 : 8'(idx + 100));
            nd += int'(frame_done);
            if (out_valid === 1'b1 && first_v < 0) first_v = idx;
            n_tests++;
            if (out_valid !== exp_valid || frame_done !== exp_done ||
                (exp_valid && {i_1, i_2, i_3, i_4, i_5, out_row, out_col} !==
                 {exp_win[0], exp_win[1], exp_win[2], exp_win[3], exp_win[4], exp_r, exp_c})) begin
                n_fail++;
                $display("FAIL fs_new_px%0d: got v=%b d=%b r=%0d c=%0d i1=%h i5=%h want v=%b d=%b r=%0d c=%0d i1=%h i5=%h",
                         idx, out_valid, frame_done, out_row, out_col, i_1, i_5,
                         exp_valid, exp_done, exp_r, exp_c, exp_win[0], exp_win[4]);
            end
        end
        n_tests++;
        if (first_v != 36 || nd != 1) begin
            n_fail++;
            $display("FAIL fs_summary: got first_valid_px=%0d done=%0d want first_valid_px=36 done=1", first_v, nd);
        end
    endtask

    task automatic test_async_reset();
        for (int idx = 0; idx < 21; idx++) step(1'b1, 1'b0, 8'(idx));
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ((|{out_valid, frame_done, out_row, out_col, i_1, i_2, i_3, i_4, i_5}) !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got v=%b r=%0d c=%0d i1=%h i5=%h want all zero",
                     out_valid, out_row, out_col, i_1, i_5);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        mr = 0; mc = 0;
        for (int idx = 0; idx < W*H; idx++) begin
            step(1'b1, 1'b0, 8'(idx));
            n_tests++;
            if (out_valid !== exp_valid || frame_done !== exp_done ||
                (exp_valid && {i_1, i_2, i_3, i_4, i_5, out_row, out_col} !==
                 {exp_win[0], exp_win[1], exp_win[2], exp_win[3], exp_win[4], exp_r, exp_c})) begin
                n_fail++;
                $display("FAIL rst_px%0d: got v=%b d=%b r=%0d c=%0d i1=%h i5=%h want v=%b d=%b r=%0d c=%0d i1=%h i5=%h",
                         idx, out_valid, frame_done, out_row, out_col, i_1, i_5,
                         exp_valid, exp_done, exp_r, exp_c, exp_win[0], exp_win[4]);
            end
            if (idx == 36) begin
                n_tests++;
                if (out_valid !== 1'b1 || i_1 !== 40'h0403020100 || i_5 !== 40'h2423222120) begin
                    n_fail++;
                    $display("FAIL rst_first_window: got v=%b i1=%h i5=%h want v=1 i1=0403020100 i5=2423222120",
                             out_valid, i_1, i_5);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0, nd = 0;
        for (int idx = 0; idx < 2*W*H; idx++) begin
            step(1'b1, 1'b0, (idx < W*H) ? 8'(idx) : (8'(idx - W*H) ^ 8'hFF));
            nv += int'(out_valid); nd += int'(frame_done);
            n_tests++;
            if (out_valid !== exp_valid || frame_done !== exp_done ||
                (exp_valid && {i_1, i_2, i_3, i_4, i_5, out_row, out_col} !==
                 {exp_win[0], exp_win[1], exp_win[2], exp_win[3], exp_win[4], exp_r, exp_c})) begin
                n_fail++;
                $display("FAIL b2b_px%0d: got v=%b d=%b r=%0d c=%0d i1=%h i5=%h want v=%b d=%b r=%0d c=%0d i1=%h i5=%h",
                         idx, out_valid, frame_done, out_row, out_col, i_1, i_5,
                         exp_valid, exp_done, exp_r, exp_c, exp_win[0], exp_win[4]);
            end
            if (idx == W*H + 36) begin
                n_tests++;
                if (out_valid !== 1'b1 || i_1 !== 40'hFBFCFDFEFF) begin
                    n_fail++;
                    $display("FAIL b2b_frame2_first: got v=%b i1=%h want v=1 i1=fbfcfdfeff", out_valid, i_1);
                end
            end
        end
        n_tests++;
        if (nv != 16 || nd != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got valid=%0d done=%0d want valid=16 done=2", nv, nd);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_random_idle();
        test_frame_start();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
